// File: rtl/bsg_link_pkg.sv
// Shared link definitions: beats per word, byte-lane map and word type.
package bsg_link_pkg;

  localparam int BEATS_PER_WORD = 4;

  // Indexed by beat number; entry is the destination byte lane for each channel.
  localparam logic [3:0][2:0] LANE_CH0 = {3'd5, 3'd4, 3'd1, 3'd0};
  localparam logic [3:0][2:0] LANE_CH1 = {3'd7, 3'd6, 3'd3, 3'd2};

  typedef logic [63:0] link_word_t;

endpackage

// File: rtl/bsg_downstream_fifo.sv
// Word FIFO between link assembly and core; data output reads 0 when empty.
module bsg_downstream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ready_o = (cnt_q != CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign do_push = push_i & ready_o;
  assign do_pop  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_downstream_in.sv
// Link-to-core word assembler: four 2-byte beats form one 64-bit word.
// Optional link parity checking is built when BSG_DOWNSTREAM_IN_PARITY_EN is defined.
//
// beat | lanes filled (ch0, ch1)
// 0    | byte0, byte2
// 1    | byte1, byte3
// 2    | byte4, byte6
// 3    | byte5, byte7, word pushed
module bsg_downstream_in
  import bsg_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_valid_in,
  input  logic [7:0]  io_data_in_ch0,
  input  logic [7:0]  io_data_in_ch1,
  output logic        io_ready_out,
  output logic        core_valid_out,
  output logic [63:0] core_data_out,
  input  logic        core_ready_in
`ifdef BSG_DOWNSTREAM_IN_PARITY_EN
  ,input  logic [1:0] io_parity_in
  ,output logic       err_sticky
`endif
);

  logic [1:0] beat_q, beat_d;
  link_word_t word_q, word_d;
  logic       fifo_ready;
  logic       accept;
  logic       push;

  assign io_ready_out = fifo_ready;
  assign accept       = io_valid_in & fifo_ready;
  assign push         = accept && (beat_q == 2'(BEATS_PER_WORD - 1));

  // The completed word goes to the FIFO straight from word_d so it lands on the beat3 edge.
  always_comb begin
    beat_d = beat_q;
    word_d = word_q;
    if (accept) begin
      beat_d = beat_q + 2'd1;
      word_d[{LANE_CH0[beat_q], 3'b000} +: 8] = io_data_in_ch0;
      word_d[{LANE_CH1[beat_q], 3'b000} +: 8] = io_data_in_ch1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      word_q <= '0;
    end else begin
      beat_q <= beat_d;
      word_q <= word_d;
    end
  end

  bsg_downstream_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (word_d),
    .ready_o(fifo_ready),
    .pop_i  (core_ready_in),
    .valid_o(core_valid_out),
    .data_o (core_data_out)
  );

`ifdef BSG_DOWNSTREAM_IN_PARITY_EN
  logic err_q;
  logic par_bad;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign par_bad = ~(^{io_data_in_ch0, io_parity_in[0]}) |
                   ~(^{io_data_in_ch1, io_parity_in[1]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err_q <= 1'b0;
    else if (accept && par_bad) err_q <= 1'b1;
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_bsg_downstream_in.sv
// Directed-vector bench for bsg_downstream_in (FIFO_DEPTH=2).
module tb_bsg_downstream_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_valid_in = 1'b0;
  logic [7:0]  ch0 = 8'h00;
  logic [7:0]  ch1 = 8'h00;
  logic        core_ready_in = 1'b0;
  logic        io_ready_out;
  logic        core_valid_out;
  logic [63:0] core_data_out;

  int n_app  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

`ifdef BSG_DOWNSTREAM_IN_PARITY_EN
  logic [1:0] par_flip = 2'b00;
  logic [1:0] io_parity_in;
  logic       err_sticky;
  assign io_parity_in = {~^ch1, ~^ch0} ^ par_flip;
`endif

  bsg_downstream_in #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_valid_in   (io_valid_in),
    .io_data_in_ch0(ch0),
    .io_data_in_ch1(ch1),
    .io_ready_out  (io_ready_out),
    .core_valid_out(core_valid_out),
    .core_data_out (core_data_out),
    .core_ready_in (core_ready_in)
`ifdef BSG_DOWNSTREAM_IN_PARITY_EN
    ,.io_parity_in (io_parity_in)
    ,.err_sticky   (err_sticky)
`endif
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic        cr;
    logic [1:0]  flip;
    logic        e_rdy;
    logic        e_vld;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] W0 = 64'h8877665544332211;
  localparam logic [63:0] WA = 64'h0806070504020301;
  localparam logic [63:0] WB = 64'h1816171514121311;
  localparam logic [63:0] WC = 64'h2826272524222321;

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] c0,
                              input logic [7:0] c1, input logic cr, input logic er,
                              input logic ev, input logic [63:0] ed);
    vec_t t;
    t.rst = r; t.vld = v; t.c0 = c0; t.c1 = c1; t.cr = cr; t.flip = 2'b00;
    t.e_rdy = er; t.e_vld = ev; t.e_data = ed;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    rst           = v.rst;
    io_valid_in   = v.vld;
    ch0           = v.c0;
    ch1           = v.c1;
    core_ready_in = v.cr;
`ifdef BSG_DOWNSTREAM_IN_PARITY_EN
    par_flip      = v.flip;
`endif
    #1;
    n_app++;
    if (io_ready_out !== v.e_rdy || core_valid_out !== v.e_vld ||
        core_data_out !== v.e_data) begin
      n_miss++;
      $display("FAIL %s: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
               name, io_ready_out, core_valid_out, core_data_out,
               v.e_rdy, v.e_vld, v.e_data);
    end
  endtask

  logic [7:0] a_c0[4] = '{8'h01, 8'h03, 8'h05, 8'h07};
  logic [7:0] a_c1[4] = '{8'h02, 8'h04, 8'h06, 8'h08};
  logic [7:0] b_c0[4] = '{8'h11, 8'h13, 8'h15, 8'h17};
  logic [7:0] b_c1[4] = '{8'h12, 8'h14, 8'h16, 8'h18};

  initial begin
    // basic word, core always ready
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h11, 8'h33, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h22, 8'h44, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h55, 8'h77, 1, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h66, 8'h88, 1, 1, 0, '0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, W0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, '0));
    // same word with invalid-beat gaps, then held while core stalls
    vecs.push_back(mk(0, 1, 8'h11, 8'h33, 0, 1, 0, '0));
    vecs.push_back(mk(0, 0, 8'hFF, 8'hFF, 0, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h22, 8'h44, 0, 1, 0, '0));
    vecs.push_back(mk(0, 0, 8'hFF, 8'hFF, 0, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h55, 8'h77, 0, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'h66, 8'h88, 0, 1, 0, '0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, W0));
    vecs.push_back(mk(0, 0, 8'hFF, 8'hFF, 0, 1, 1, W0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, W0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, '0));
    // backpressure: A and B fill the FIFO, C beat0 stalls
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, a_c0[i], a_c1[i], 0, 1, 0, '0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, b_c0[i], b_c1[i], 0, 1, 1, WA));
    vecs.push_back(mk(0, 1, 8'h21, 8'h22, 0, 0, 1, WA));
    vecs.push_back(mk(0, 1, 8'h21, 8'h22, 0, 0, 1, WA));
    vecs.push_back(mk(0, 1, 8'h21, 8'h22, 1, 0, 1, WA));
    vecs.push_back(mk(0, 1, 8'h21, 8'h22, 0, 1, 1, WB));
    vecs.push_back(mk(0, 1, 8'h23, 8'h24, 0, 1, 1, WB));
    vecs.push_back(mk(0, 1, 8'h25, 8'h26, 0, 1, 1, WB));
    vecs.push_back(mk(0, 1, 8'h27, 8'h28, 1, 1, 1, WB));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, WC));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, WC));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, '0));
    // reset with a queued word and a 2-beat partial, then a fresh word
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, b_c0[i], b_c1[i], 0, 1, 0, '0));
    vecs.push_back(mk(0, 1, 8'hAA, 8'hBB, 0, 1, 1, WB));
    vecs.push_back(mk(0, 1, 8'hCC, 8'hDD, 0, 1, 1, WB));
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 1, 0, '0));
    vecs.push_back(mk(1, 1, 8'hEE, 8'hEE, 0, 1, 0, '0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, a_c0[i], a_c1[i], 1, 1, 0, '0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, WA));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, '0));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // long full stall: head must stay put, ready low, valid beat ignored
    for (int i = 0; i < 4; i++) step(mk(0, 1, a_c0[i], a_c1[i], 0, 1, 0, '0), "fill_a");
    for (int i = 0; i < 4; i++) step(mk(0, 1, b_c0[i], b_c1[i], 0, 1, 1, WA), "fill_b");
    for (int i = 0; i < 5; i++) step(mk(0, 1, 8'h99, 8'h99, 0, 0, 1, WA), "full_hold");
    step(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, WA), "drain_a");
    step(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, WB), "drain_b");
    step(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, '0), "drained");

`ifdef BSG_DOWNSTREAM_IN_PARITY_EN
    begin
      vec_t pv;
      step(mk(1, 0, 8'h00, 8'h00, 1, 1, 0, '0), "par_rst");
      n_app++;
      if (err_sticky !== 1'b0) begin n_miss++; $display("FAIL err_reset: got %b want 0", err_sticky); end
      pv = mk(0, 1, 8'h5A, 8'h3C, 1, 1, 0, '0);
      pv.flip = 2'b01;
      step(pv, "par_bad_beat");
      n_app++;
      if (err_sticky !== 1'b0) begin n_miss++; $display("FAIL err_early: got %b want 0", err_sticky); end
      for (int i = 0; i < 3; i++) begin
        step(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, '0), "par_idle");
        n_app++;
        if (err_sticky !== 1'b1) begin n_miss++; $display("FAIL err_set%0d: got %b want 1", i, err_sticky); end
      end
      step(mk(1, 0, 8'h00, 8'h00, 1, 1, 0, '0), "par_clear");
      n_app++;
      if (err_sticky !== 1'b0) begin n_miss++; $display("FAIL err_clear: got %b want 0", err_sticky); end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_miss);
    $finish;
  end

endmodule

// File: doc/bsg_downstream_in.md
BSG_DOWNSTREAM_IN -- requirements
Module: bsg_downstream_in

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, giving the number of assembled 64-bit words buffered toward the core (legal values 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port io_valid_in, input, 1 bit: the link beat on the ch0/ch1 inputs is valid.
REQ-005 The block SHALL have port io_data_in_ch0, input, 8 bits: channel-0 byte of the current beat.
REQ-006 The block SHALL have port io_data_in_ch1, input, 8 bits: channel-1 byte of the current beat.
REQ-007 The block SHALL have port io_ready_out, output, 1 bit: the block can accept a beat this cycle.
REQ-008 The block SHALL have port core_valid_out, output, 1 bit: core_data_out holds a complete word.
REQ-009 The block SHALL have port core_data_out, output, 64 bits: the assembled word.
REQ-010 The block SHALL have port core_ready_in, input, 1 bit: the core accepts the word this cycle.

Function
REQ-011 A beat SHALL be accepted only in a cycle where io_valid_in=1 and io_ready_out=1.
REQ-012 Four accepted beats SHALL form one word, using a 2-bit beat counter that wraps 3->0.
REQ-013 The beat mapping SHALL be: beat0 ch0->byte0, ch1->byte2; beat1 ch0->byte1, ch1->byte3; beat2 ch0->byte4, ch1->byte6; beat3 ch0->byte5, ch1->byte7. Byte k is data[8k+7:8k].
REQ-014 The word SHALL be pushed into the FIFO in the cycle it is completed, on acceptance of beat3. It SHALL be visible on core_valid_out on the next cycle, giving 1 cycle of latency from the beat3 edge.
REQ-015 io_ready_out SHALL be combinational and equal to 1 whenever the FIFO count < FIFO_DEPTH, independent of io_valid_in.
REQ-016 A word SHALL be popped in any cycle where core_valid_out=1 and core_ready_in=1.
REQ-017 core_data_out SHALL be the FIFO head and SHALL stay stable while core_valid_out=1 and core_ready_in=0.
REQ-018 A push and a pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full.
REQ-019 When the FIFO is full, io_ready_out SHALL be 0 and the partial-word beat counter and bytes SHALL hold.
REQ-020 Beats with io_valid_in=0 SHALL NOT advance the beat counter.
REQ-021 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL be clog2(FIFO_DEPTH+1) bits wide.

Reset
REQ-022 Asserting rst at any time SHALL immediately clear the beat counter, the FIFO count and the pointers, and SHALL discard any partial word.
REQ-023 During and after reset: core_valid_out=0, core_data_out=0, io_ready_out=1.
REQ-024 The partial-word byte register SHALL reset to 0.

Configuration
REQ-025 Macro BSG_DOWNSTREAM_IN_PARITY_EN SHALL control link parity.
- Defined: adds input io_parity_in, 2 bits, carrying odd parity of ch0 and ch1 per beat, and output err_sticky, 1 bit.
- Defined: any accepted beat with mismatched parity SHALL set err_sticky on the next edge. Only rst clears it. The word is still delivered.
- Undefined: neither port exists and no parity logic is built.

Structure
REQ-026 Shared package bsg_link_pkg SHALL hold: the beat-count constant (4), the byte-lane mapping table of REQ-013, and typedef link_word_t (64 bits).
REQ-027 The FIFO SHALL be a sub-module named bsg_downstream_fifo, parameterised by FIFO_DEPTH and width 64. The assembly FSM SHALL stay in the top.

Verification
REQ-028 Send beats (ch0,ch1) = (11,33),(22,44),(55,77),(66,88), one per cycle, with core_ready_in=1 -> one cycle after beat3, core_valid_out=1 and core_data_out=64'h8877665544332211.
REQ-029 Hold core_ready_in=0, FIFO_DEPTH=2, and stream 3 words -> io_ready_out drops after word 2. Beat0 of word 3 stalls. Raising core_ready_in drains words in order and word 3 completes intact.
REQ-030 Insert io_valid_in=0 gaps between beats -> the assembled word is identical to the gap-free case.
REQ-031 FIFO full with core_ready_in=1 in the cycle beat3 of the next word arrives -> count unchanged and no word lost. This requires the word-3 beats to be accepted after ready returns.
REQ-032 Assert rst after 2 beats, then send 4 fresh beats -> the output word contains only the fresh bytes, and core_valid_out=0 while rst is high.
REQ-033 With BSG_DOWNSTREAM_IN_PARITY_EN defined, send one beat with flipped io_parity_in[0] -> err_sticky=1 from the next cycle until rst.
